// File: rtl/quadrato_pkg.sv
// Shared constants and FSM state for the square motion controller.
// Coordinates are 11 bits; axis arithmetic uses a 12-bit intermediate.
package quadrato_pkg;

  localparam int H_DEF = 1280;
  localparam int V_DEF = 1024;
  localparam int CW    = 11;
  localparam int IW    = 12;

  typedef enum logic [1:0] {
    ATTESA,
    CALC_X,
    CALC_Y,
    COMMIT
  } state_t;

endpackage

// File: rtl/calcolo_asse.sv
// Single-axis step: moves a coordinate by PASSO in either direction,
// wrapping modulo MODULO or clamping to [lim_lo, lim_hi].
module calcolo_asse
  import quadrato_pkg::*;
#(
  parameter int PASSO  = 4,
  parameter int MODULO = H_DEF
) (
  input  logic [CW-1:0] pos,
  input  logic          dir,
  input  logic          move,
  input  logic          wrap,
  input  logic [CW-1:0] lim_lo,
  input  logic [CW-1:0] lim_hi,
  output logic [CW-1:0] pos_new,
  output logic          limit_hit
);

  localparam logic [IW-1:0] STEP = IW'(PASSO);
  localparam logic [IW-1:0] MODW = IW'(MODULO);

  logic [IW-1:0] p;
  logic [IW-1:0] up;

  assign p  = {1'b0, pos};
  assign up = p + STEP;

  always_comb begin
    pos_new   = pos;
    limit_hit = 1'b0;
    if (move) begin
      unique case ({wrap, dir})
        2'b11: pos_new = (up >= MODW) ? CW'(up - MODW)
                                      : up[CW-1:0];
        2'b10: pos_new = (p < STEP) ? CW'(p + MODW - STEP)
                                    : CW'(p - STEP);
        2'b01: begin
          if (up > {1'b0, lim_hi}) begin
            pos_new   = lim_hi;
            limit_hit = 1'b1;
          end else begin
            pos_new = up[CW-1:0];
          end
        end
        default: begin
          // compare before subtracting so a small pos cannot underflow
          if (p < {1'b0, lim_lo} + STEP) begin
            pos_new   = lim_lo;
            limit_hit = 1'b1;
          end else begin
            pos_new = CW'(p - STEP);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/quadrato_motore.sv
// Motion controller for the on-screen square: divides frame ticks,
// steps X (wrap) then Y (clamp/bounce), and commits both at once.
module quadrato_motore
  import quadrato_pkg::*;
#(
  parameter int H         = H_DEF,
  parameter int V         = V_DEF,
  parameter int ALTEZZA   = 100,
  parameter int LARGHEZZA = 100,
  parameter int X_INIT    = 640,
  parameter int Y_INIT    = 512,
  parameter int PASSO     = 4,
  parameter int FRAME_DIV = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FRAME_TICK,
  input  logic          ENABLE,
  input  logic          MODO,
  input  logic          BTN_SU,
  input  logic          BTN_GIU,
  input  logic          BTN_SX,
  input  logic          BTN_DX,
  output logic [CW-1:0] X_POS,
  output logic [CW-1:0] Y_POS,
  output logic          AGGIORNATO,
  output logic          RIMBALZO,
  output logic          BUSY
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);
  localparam logic [CW-1:0] Y_LO = CW'(ALTEZZA / 2);
  localparam logic [CW-1:0] Y_HI = CW'(V - 1 - ALTEZZA / 2);

  if (FRAME_DIV < 1 || LARGHEZZA > H || ALTEZZA >= V) begin : g_bad_param
    $error("quadrato_motore: inconsistent parameters");
  end

  state_t        state, state_n;
  logic [DW-1:0] div;
  logic          m_mode, m_su, m_giu, m_sx, m_dx;
  logic          dir_x, dir_y;
  logic [CW-1:0] shadow_x;
  logic [CW-1:0] x_q, y_q;
  logic          rimb_q;

  logic          tick_ok;
  logic          is_y;
  logic          mv_x, dr_x, mv_y, dr_y;
  logic [CW-1:0] c_pos, c_new;
  logic          c_dir, c_move, c_hit;

  assign tick_ok = (state == ATTESA) && FRAME_TICK && ENABLE;
  assign is_y    = (state == CALC_Y);

  always_comb begin
    mv_x = 1'b0;
    dr_x = dir_x;
    mv_y = 1'b0;
    dr_y = dir_y;
    if (!m_mode) begin
      mv_x = 1'b1;
      mv_y = 1'b1;
    end else begin
      unique case (1'b1)
        m_dx & ~m_sx: begin mv_x = 1'b1; dr_x = 1'b1; end
        m_sx & ~m_dx: begin mv_x = 1'b1; dr_x = 1'b0; end
        default: ;
      endcase
      unique case (1'b1)
        m_giu & ~m_su: begin mv_y = 1'b1; dr_y = 1'b1; end
        m_su & ~m_giu: begin mv_y = 1'b1; dr_y = 1'b0; end
        default: ;
      endcase
    end
  end

  // one axis unit, shared between CALC_X and CALC_Y
  assign c_pos  = is_y ? y_q  : x_q;
  assign c_dir  = is_y ? dr_y : dr_x;
  assign c_move = is_y ? mv_y : mv_x;

  calcolo_asse #(
    .PASSO  (PASSO),
    .MODULO (H)
  ) u_asse (
    .pos       (c_pos),
    .dir       (c_dir),
    .move      (c_move),
    .wrap      (~is_y),
    .lim_lo    (Y_LO),
    .lim_hi    (Y_HI),
    .pos_new   (c_new),
    .limit_hit (c_hit)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ATTESA: if (tick_ok && div == DIV_LAST) state_n = CALC_X;
      CALC_X: state_n = CALC_Y;
      CALC_Y: state_n = COMMIT;
      COMMIT: state_n = ATTESA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ATTESA;
      div      <= '0;
      m_mode   <= 1'b0;
      m_su     <= 1'b0;
      m_giu    <= 1'b0;
      m_sx     <= 1'b0;
      m_dx     <= 1'b0;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      shadow_x <= '0;
      rimb_q   <= 1'b0;
      x_q      <= CW'(X_INIT);
      y_q      <= CW'(Y_INIT);
    end else begin
      state <= state_n;
      if (tick_ok) begin
        if (div == DIV_LAST) begin
          div    <= '0;
          m_mode <= MODO;
          m_su   <= BTN_SU;
          m_giu  <= BTN_GIU;
          m_sx   <= BTN_SX;
          m_dx   <= BTN_DX;
        end else begin
          div <= div + DW'(1);
        end
      end
      if (state == CALC_X) shadow_x <= c_new;
      // both coordinates land together on entry to COMMIT
      if (is_y) begin
        x_q    <= shadow_x;
        y_q    <= c_new;
        rimb_q <= ~m_mode & c_hit;
        if (~m_mode & c_hit) dir_y <= ~dir_y;
      end
    end
  end

  assign X_POS      = x_q;
  assign Y_POS      = y_q;
  assign AGGIORNATO = (state == COMMIT);
  assign RIMBALZO   = (state == COMMIT) & rimb_q;
  assign BUSY       = (state != ATTESA);

endmodule

// File: tb/tb_quadrato_motore.sv
// Directed bench for quadrato_motore: divider, latency, wrap,
// bounce, manual clamp, busy/enable/reset robustness.
module tb_quadrato_motore;

  logic        CLK = 1'b0;
  logic        RESET, FRAME_TICK, ENABLE, MODO;
  logic        BTN_SU, BTN_GIU, BTN_SX, BTN_DX;
  logic [10:0] X_POS, Y_POS;
  logic        AGGIORNATO, RIMBALZO, BUSY;

  int errors = 0;
  int checks = 0;
  int ex, ey;
  logic bad;
  logic agg_s, rb_s;
  logic [10:0] xs, ys;

  always #5 CLK = ~CLK;

  quadrato_motore dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FRAME_TICK (FRAME_TICK),
    .ENABLE     (ENABLE),
    .MODO       (MODO),
    .BTN_SU     (BTN_SU),
    .BTN_GIU    (BTN_GIU),
    .BTN_SX     (BTN_SX),
    .BTN_DX     (BTN_DX),
    .X_POS      (X_POS),
    .Y_POS      (Y_POS),
    .AGGIORNATO (AGGIORNATO),
    .RIMBALZO   (RIMBALZO),
    .BUSY       (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    FRAME_TICK = 1'b1;
    @(negedge CLK);
    FRAME_TICK = 1'b0;
  endtask

  // two ticks (divider 0 -> 1 -> accept); samples the commit cycle
  task automatic update(input logic flip);
    pulse();
    repeat (3) @(negedge CLK);
    pulse();
    if (flip) begin
      BTN_SX = ~BTN_SX; BTN_DX = ~BTN_DX;
      BTN_SU = ~BTN_SU; BTN_GIU = ~BTN_GIU;
    end
    repeat (2) @(negedge CLK);
    agg_s = AGGIORNATO;
    rb_s  = RIMBALZO;
    xs    = X_POS;
    ys    = Y_POS;
    @(negedge CLK);
    if (flip) begin
      BTN_SX = ~BTN_SX; BTN_DX = ~BTN_DX;
      BTN_SU = ~BTN_SU; BTN_GIU = ~BTN_GIU;
    end
  endtask

  task automatic watch_idle(input int n);
    bad = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      if (AGGIORNATO !== 1'b0 || BUSY !== 1'b0 || RIMBALZO !== 1'b0)
        bad = 1'b1;
    end
  endtask

  initial begin
    RESET = 1'b1; FRAME_TICK = 1'b0; ENABLE = 1'b0; MODO = 1'b0;
    BTN_SU = 1'b0; BTN_GIU = 1'b0; BTN_SX = 1'b0; BTN_DX = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    watch_idle(10);
    chk("reset_x", X_POS, 640);
    chk("reset_y", Y_POS, 512);
    chk("reset_flags_idle", bad, 0);

    // divider and latency
    ENABLE = 1'b1;
    pulse();
    watch_idle(5);
    chk("div_first_tick_idle", bad, 0);
    chk("div_first_tick_x", X_POS, 640);
    pulse();
    chk("lat_t1_busy", BUSY, 1);
    chk("lat_t1_x", X_POS, 640);
    @(negedge CLK);
    chk("lat_t2_agg", AGGIORNATO, 0);
    chk("lat_t2_y", Y_POS, 512);
    @(negedge CLK);
    chk("lat_t3_agg", AGGIORNATO, 1);
    chk("lat_t3_x", X_POS, 644);
    chk("lat_t3_y", Y_POS, 516);
    chk("lat_t3_rimb", RIMBALZO, 0);
    @(negedge CLK);
    chk("lat_t4_agg", AGGIORNATO, 0);
    chk("lat_t4_busy", BUSY, 0);

    // ENABLE=0 tick must not advance the divider
    ENABLE = 1'b0;
    pulse();
    ENABLE = 1'b1;
    repeat (2) @(negedge CLK);
    pulse();
    watch_idle(4);
    chk("enable_low_div_hold", bad, 0);
    pulse();
    pulse();
    @(negedge CLK);
    chk("busy_tick_agg", AGGIORNATO, 1);
    chk("busy_tick_x", X_POS, 648);
    chk("busy_tick_y", Y_POS, 520);
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    pulse();
    watch_idle(4);
    chk("busy_tick_div_hold", bad, 0);
    pulse();
    repeat (2) @(negedge CLK);
    chk("div_resume_x", X_POS, 652);
    chk("div_resume_y", Y_POS, 524);
    @(negedge CLK);

    // auto mode down to the lower limit
    ex = 652; ey = 524;
    for (int i = 0; i < 112; i++) begin
      update(1'b0);
      ex += 4; ey += 4;
      chk("auto_down_x", xs, ex);
      chk("auto_down_y", ys, ey);
      chk("auto_down_rimb", rb_s, 0);
    end
    chk("auto_reach_972", ys, 972);
    update(1'b0);
    chk("bounce_y", ys, 973);
    chk("bounce_rimb", rb_s, 1);
    chk("bounce_agg", agg_s, 1);
    chk("bounce_x", xs, 1104);
    update(1'b0);
    chk("after_bounce_y", ys, 969);
    chk("after_bounce_rimb", rb_s, 0);
    ex = 1108; ey = 969;
    for (int i = 0; i < 42; i++) begin
      update(1'b0);
      ex += 4; ey -= 4;
      chk("auto_up_x", xs, ex);
      chk("auto_up_y", ys, ey);
    end
    chk("auto_reach_1276", xs, 1276);
    update(1'b0);
    chk("wrap_plus_x", xs, 0);
    chk("wrap_plus_y", ys, 797);

    // manual mode; flip proves buttons are latched at acceptance
    MODO = 1'b1;
    BTN_SX = 1'b1;
    update(1'b1);
    chk("wrap_minus_x", xs, 1276);
    chk("man_sx_y", ys, 797);
    chk("man_sx_rimb", rb_s, 0);
    BTN_SX = 1'b0; BTN_DX = 1'b1;
    update(1'b0);
    chk("man_dx_wrap_x", xs, 0);
    BTN_SX = 1'b1;
    update(1'b0);
    chk("man_sx_dx_x", xs, 0);
    chk("man_sx_dx_agg", agg_s, 1);
    BTN_SX = 1'b0; BTN_DX = 1'b0;
    BTN_SU = 1'b1; BTN_GIU = 1'b1;
    update(1'b0);
    chk("man_su_giu_y", ys, 797);
    chk("man_su_giu_rimb", rb_s, 0);
    chk("man_su_giu_x", xs, 0);
    BTN_SU = 1'b0;
    update(1'b0);
    chk("man_giu_y", ys, 801);

    // reset while in CALC_Y discards the pending update
    pulse();
    repeat (3) @(negedge CLK);
    pulse();
    @(negedge CLK);
    chk("midreset_calc_busy", BUSY, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midreset_x", X_POS, 640);
    chk("midreset_y", Y_POS, 512);
    chk("midreset_agg", AGGIORNATO, 0);
    chk("midreset_busy", BUSY, 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midreset_agg_after", AGGIORNATO, 0);
    chk("midreset_y_after", Y_POS, 512);

    // manual up to the upper clamp
    BTN_GIU = 1'b0; BTN_SU = 1'b1;
    ey = 512;
    for (int i = 0; i < 115; i++) begin
      update(1'b0);
      ey -= 4;
      chk("man_up_y", ys, ey);
      chk("man_up_x", xs, 640);
    end
    chk("man_reach_52", ys, 52);
    update(1'b0);
    chk("man_clamp_y", ys, 50);
    chk("man_clamp_rimb", rb_s, 0);
    update(1'b0);
    chk("man_clamp_hold_y", ys, 50);
    chk("man_clamp_hold_agg", agg_s, 1);
    chk("man_clamp_hold_rimb", rb_s, 0);

    // dir_y back to down after reset
    MODO = 1'b0; BTN_SU = 1'b0;
    update(1'b0);
    chk("auto_after_reset_y", ys, 54);
    chk("auto_after_reset_x", xs, 644);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quadrato_motore.md
Name: quadrato_motore

Overview:
- Motion controller for the on-screen square drawn by the rectangle/frame hit-test logic.
- Owns the centre coordinates X_POS/Y_POS that feed the hit-test blocks.
- Updates them once per FRAME_DIV frames, either autonomously (bouncing vertically, wrapping horizontally) or from direction buttons.
- Outputs change only in a single commit cycle, so the renderer never sees a half-updated position.

Parameters:
H, 1280, horizontal active pixels; X wrap modulus
V, 1024, vertical active lines
ALTEZZA, 100, square height in pixels
LARGHEZZA, 100, square width in pixels (reported only; X wraps, no clamp)
X_INIT, 640, X_POS reset value
Y_INIT, 512, Y_POS reset value
PASSO, 4, pixels moved per update per axis
FRAME_DIV, 2, frames per update (>=1)

Ports:
CLK  input  1  system/pixel clock
RESET  input  1  synchronous, active-high reset
FRAME_TICK  input  1  one-cycle pulse at end of active frame
ENABLE  input  1  motion enable; 0 freezes position and divider
MODO  input  1  0 = automatic bounce, 1 = manual buttons
BTN_SU  input  1  manual: move up (Y decreasing)
BTN_GIU  input  1  manual: move down
BTN_SX  input  1  manual: move left
BTN_DX  input  1  manual: move right
X_POS  output  11  centre X of square
Y_POS  output  11  centre Y of square
AGGIORNATO  output  1  one-cycle pulse in the commit cycle
RIMBALZO  output  1  one-cycle pulse, with AGGIORNATO, when auto mode reverses Y direction
BUSY  output  1  high while in CALC_X, CALC_Y or COMMIT

Behaviour:
- Reset (synchronous, any state):
  - X_POS=X_INIT, Y_POS=Y_INIT.
  - Direction registers: dir_x=+, dir_y=+ (down).
  - Frame divider=0; shadow registers=0.
  - AGGIORNATO, RIMBALZO, BUSY = 0; state=ATTESA.
  - A reset mid-update discards the shadow values; outputs never take them.
- FSM states: ATTESA -> CALC_X -> CALC_Y -> COMMIT -> ATTESA.
- ATTESA:
  - On FRAME_TICK with ENABLE=1: if divider==FRAME_DIV-1, clear divider, sample MODO and the four buttons, go to CALC_X; otherwise increment divider.
  - FRAME_TICK with ENABLE=0 is ignored; the divider holds.
- CALC_X: compute shadow X from a 12-bit intermediate.
  - +PASSO: if X+PASSO >= H, result is X+PASSO-H.
  - -PASSO: if X < PASSO, result is X+H-PASSO.
  - Direction source: auto uses dir_x. Manual uses DX only -> +, SX only -> -, both or neither -> no move.
- CALC_Y: legal range is [ALTEZZA/2, V-1-ALTEZZA/2].
  - Auto mode: step by dir_y. If the result crosses a limit, clamp to the limit, invert dir_y, and set the RIMBALZO flag.
  - Manual mode: GIU only -> +, SU only -> -, both or neither -> no move. Clamp at limits; no direction change and no RIMBALZO.
- COMMIT: X_POS/Y_POS <= shadow; AGGIORNATO=1; RIMBALZO=flag; return to ATTESA.
- Latency: an accepted FRAME_TICK in cycle t gives new outputs and AGGIORNATO visible in cycle t+3.
- FRAME_TICK while BUSY=1 is ignored and does not advance the divider.
- The button and mode sample taken at acceptance is used for the whole update; later changes do not affect it.
- dir_x is never changed in auto mode (horizontal motion wraps continuously).

Decomposition:
- Shared package quadrato_pkg:
  - Constants H, V, coordinate width 11, intermediate width 12.
  - FSM state enum {ATTESA, CALC_X, CALC_Y, COMMIT}.
- One natural sub-module: calcolo_asse.
  - Combinational single-axis step.
  - Inputs: position, direction, move enable, mode (wrap vs clamp), limits.
  - Outputs: new position, limit_hit.
  - Instantiated twice, or time-shared across CALC_X/CALC_Y.

Test Plan:
- Reset: RESET=1 for 2 cycles, then idle 10 cycles -> X_POS=640, Y_POS=512; AGGIORNATO, RIMBALZO and BUSY stay 0.
- Divider and latency: FRAME_DIV=2, auto, ENABLE=1, FRAME_TICK at cycles 10 and 20.
  - Tick at cycle 10 -> no update.
  - Tick at cycle 20 -> X_POS=644, Y_POS=516 at cycle 23, AGGIORNATO pulses one cycle at 23.
- X wrap: preload X=1278 (auto, dir +), one update -> X_POS=2. Manual SX with X=2 -> X_POS=1278.
- Y bounce: auto, Y=972 (lower limit 973), dir down -> Y_POS=973 with RIMBALZO=1; next update Y_POS=969.
- Manual mode:
  - BTN_SU+BTN_GIU together -> Y unchanged, no RIMBALZO.
  - BTN_SU at Y=52 -> Y_POS=50, clamped at the upper limit.
- Robustness:
  - FRAME_TICK at t+1 during BUSY -> ignored, divider unchanged.
  - RESET asserted in CALC_Y -> X_POS=640, Y_POS=512 next cycle, no AGGIORNATO.
